// File: rtl/irq_timer_ctrl.sv
// Multi-source interrupt controller: NCNT periodic down-counter channels plus NEXT
// edge-triggered external lines, fixed priority, request/take/return handshake to fetch.
module irq_timer_ctrl #(
  parameter int unsigned NCNT = 4,
  parameter int unsigned NEXT = 2,
  parameter int unsigned CNTW = 16,
  parameter int unsigned IDW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 cnt_int_we,
  input  logic                 cnt_int_sel,
  input  logic                 cnt_int_disable,
  input  logic [IDW-1:0]       cnt_ch,
  input  logic [CNTW-1:0]      cnt_period,
  input  logic [NEXT-1:0]      ext_irq,
  input  logic                 int_en,
  input  logic                 int_taken,
  input  logic                 rti,
  output logic                 irq,
  output logic [IDW-1:0]       irq_id,
  output logic                 in_service,
  output logic [NCNT+NEXT-1:0] pending
);

  localparam int unsigned NSRC = NCNT + NEXT;

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  id_q, id_d, top_id;
  logic [CNTW-1:0] period_q [NCNT];
  logic [CNTW-1:0] period_d [NCNT];
  logic [CNTW-1:0] count_q  [NCNT];
  logic [CNTW-1:0] count_d  [NCNT];
  logic [NCNT-1:0] en_q, en_d;
  logic [NSRC-1:0] pend_q, pend_d, set_v, dis_v;
  logic [NEXT-1:0] ext_q;
  logic            prime_q;
  logic            cfg_ok, take_clr, id_keep;

  assign cfg_ok = cnt_int_we & ~stall & ({1'b0, cnt_ch} < (IDW + 1)'(NCNT));

  always_comb begin
    set_v = '0;
    dis_v = '0;
    for (int i = 0; i < int'(NCNT); i++) begin
      period_d[i] = period_q[i];
      count_d[i]  = count_q[i];
      en_d[i]     = en_q[i];
      if (en_q[i]) begin
        if (count_q[i] > CNTW'(1)) begin
          count_d[i] = count_q[i] - CNTW'(1);
        end else if (count_q[i] == CNTW'(1)) begin
          count_d[i] = period_q[i];
          set_v[i]   = 1'b1;
        end
      end
      if (cfg_ok && cnt_ch == IDW'(i)) begin
        if (cnt_int_disable) begin
          en_d[i]  = 1'b0;
          dis_v[i] = 1'b1;
        end else if (cnt_int_sel) begin
          period_d[i] = cnt_period;
          count_d[i]  = cnt_period;
          en_d[i]     = |cnt_period;
        end
      end
    end
    // The first sample after reset only primes the edge history, so a line
    // held high through reset does not fire.
    set_v[NSRC-1:NCNT] = prime_q ? (ext_irq & ~ext_q) : '0;
  end

  always_comb begin
    top_id = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (pend_q[i]) top_id = IDW'(i);
    end
  end

  // Whether the latched source will still be pending after this edge.
  assign id_keep = (pend_q[id_q] | set_v[id_q]) & ~dis_v[id_q];

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    take_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (int_en && |pend_q) begin
          state_d = StReq;
          id_d    = top_id;
        end
      end
      StReq: begin
        if (int_taken && !stall) begin
          take_clr = 1'b1;
          state_d  = StService;
        end else if (!int_en || !id_keep) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (rti && !stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Priority per bit: disable > new event > take-clear.
  always_comb begin
    for (int i = 0; i < int'(NSRC); i++) begin
      pend_d[i] = pend_q[i];
      if (take_clr && id_q == IDW'(i)) pend_d[i] = 1'b0;
      if (set_v[i]) pend_d[i] = 1'b1;
      if (dis_v[i]) pend_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      id_q    <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      ext_q   <= '0;
      prime_q <= 1'b0;
      for (int i = 0; i < int'(NCNT); i++) begin
        period_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      ext_q   <= ext_irq;
      prime_q <= 1'b1;
      for (int i = 0; i < int'(NCNT); i++) begin
        period_q[i] <= period_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  assign irq        = (state_q == StReq);
  assign in_service = (state_q == StService);
  assign irq_id     = id_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl; expected request ids are queued when the
// triggering stimulus is applied and popped when irq is observed.
module tb_irq_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, cnt_int_we, cnt_int_sel, cnt_int_disable;
  logic [2:0]  cnt_ch;
  logic [15:0] cnt_period;
  logic [1:0]  ext_irq;
  logic        int_en, int_taken, rti;
  logic        irq, in_service;
  logic [2:0]  irq_id;
  logic [5:0]  pending;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  irq_timer_ctrl #(.NCNT(4), .NEXT(2), .CNTW(16), .IDW(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .cnt_int_we      (cnt_int_we),
    .cnt_int_sel     (cnt_int_sel),
    .cnt_int_disable (cnt_int_disable),
    .cnt_ch          (cnt_ch),
    .cnt_period      (cnt_period),
    .ext_irq         (ext_irq),
    .int_en          (int_en),
    .int_taken       (int_taken),
    .rti             (rti),
    .irq             (irq),
    .irq_id          (irq_id),
    .in_service      (in_service),
    .pending         (pending)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_id(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed id %0d expected none queued", tag, irq_id);
    end else begin
      e = exp_q.pop_front();
      check(tag, {29'd0, irq_id}, e);
    end
  endtask

  task automatic cfg(input logic dis, input logic [2:0] ch, input logic [15:0] p);
    cnt_int_we      = 1'b1;
    cnt_int_sel     = ~dis;
    cnt_int_disable = dis;
    cnt_ch          = ch;
    cnt_period      = p;
  endtask

  task automatic cfg_off();
    cnt_int_we      = 1'b0;
    cnt_int_sel     = 1'b0;
    cnt_int_disable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; cnt_ch = '0; cnt_period = '0;
    cfg_off();
    ext_irq = 2'b11; int_en = 1'b0; int_taken = 1'b0; rti = 1'b0;
    step(2);
    check("rst_pending", pending, 0);
    check("rst_irq", irq, 0);
    check("rst_insvc", in_service, 0);
    check("rst_id", irq_id, 0);

    // External line held high through reset release
    reset = 1'b1;
    step(3);
    check("ext_held_no_event", pending, 0);
    check("ext_held_no_irq", irq, 0);
    ext_irq = 2'b00; step(1);
    ext_irq = 2'b01; step(1);
    check("ext_edge_pend", pending, 6'h10);
    exp_q.push_back(4);
    int_en = 1'b1; step(1);
    check("ext_irq", irq, 1);
    pop_id("ext_id");
    int_taken = 1'b1; step(1); int_taken = 1'b0;
    check("ext_svc", in_service, 1);
    check("ext_clr", pending, 0);
    rti = 1'b1; step(1); rti = 1'b0;
    check("ext_rti", in_service, 0);
    step(2);
    check("ext_level_once", pending, 0);
    ext_irq = 2'b00;

    // Channel 1, period 5
    cfg(1'b0, 3'd1, 16'd5); step(1); cfg_off();
    step(4);
    check("ch1_count1_nopend", pending, 0);
    step(1);
    check("ch1_pend", pending, 6'h02);
    check("ch1_noirq_yet", irq, 0);
    exp_q.push_back(1);
    step(1);
    check("ch1_irq", irq, 1);
    pop_id("ch1_id");
    int_taken = 1'b1; step(1); int_taken = 1'b0;
    check("ch1_svc", in_service, 1);
    check("ch1_clr", pending, 0);
    rti = 1'b1; step(1); rti = 1'b0;
    check("ch1_rti", in_service, 0);
    step(2);
    check("ch1_pend2", pending, 6'h02);
    exp_q.push_back(1);
    step(1);
    check("ch1_irq2", irq, 1);
    pop_id("ch1_id2");
    int_taken = 1'b1; step(1); int_taken = 1'b0;
    cfg(1'b1, 3'd1, 16'd0); step(1); cfg_off();
    rti = 1'b1; step(1); rti = 1'b0;
    step(6);
    check("ch1_disabled", pending, 0);
    check("ch1_disabled_irq", irq, 0);

    // Ch0 and external line 0 fire on the same edge
    cfg(1'b0, 3'd0, 16'd3); step(1); cfg_off();
    step(2);
    ext_irq = 2'b01; step(1);
    check("simul_pend", pending, 6'h11);
    exp_q.push_back(0);
    exp_q.push_back(4);
    step(1);
    check("simul_irq", irq, 1);
    pop_id("simul_id0");
    int_taken = 1'b1; cfg(1'b1, 3'd0, 16'd0); step(1);
    int_taken = 1'b0; cfg_off();
    check("simul_svc", in_service, 1);
    check("simul_pend_left", pending, 6'h10);
    rti = 1'b1; step(1); rti = 1'b0;
    check("simul_idle_gap", irq, 0);
    check("simul_idle_gap_svc", in_service, 0);
    step(1);
    check("simul_irq4", irq, 1);
    pop_id("simul_id4");
    int_taken = 1'b1; step(1); int_taken = 1'b0;
    rti = 1'b1; step(1); rti = 1'b0;
    ext_irq = 2'b00;
    check("simul_done", pending, 0);

    // Disable ch2 while it is being requested
    cfg(1'b0, 3'd2, 16'd4); step(1); cfg_off();
    step(4);
    check("ch2_pend", pending, 6'h04);
    exp_q.push_back(2);
    step(1);
    check("ch2_irq", irq, 1);
    pop_id("ch2_id");
    cfg(1'b1, 3'd2, 16'd0); step(1); cfg_off();
    check("ch2_dis_pend", pending, 0);
    check("ch2_dis_irq", irq, 0);
    check("ch2_dis_svc", in_service, 0);
    step(2);
    check("ch2_dis_quiet", irq, 0);

    // Stall holds off the take
    cfg(1'b0, 3'd2, 16'd20); step(1); cfg_off();
    step(20);
    check("stall_pend", pending, 6'h04);
    exp_q.push_back(2);
    step(1);
    check("stall_irq", irq, 1);
    pop_id("stall_id");
    stall = 1'b1; int_taken = 1'b1; step(3);
    check("stall_hold_irq", irq, 1);
    check("stall_hold_svc", in_service, 0);
    check("stall_hold_pend", pending, 6'h04);
    stall = 1'b0; step(1); int_taken = 1'b0;
    check("stall_take_svc", in_service, 1);
    check("stall_take_clr", pending, 0);
    rti = 1'b1; step(1); rti = 1'b0;
    cfg(1'b1, 3'd2, 16'd0); step(1); cfg_off();

    // Ch3 expiry coincides with its take
    cfg(1'b0, 3'd3, 16'd4); step(1); cfg_off();
    step(4);
    check("ch3_pend", pending, 6'h08);
    exp_q.push_back(3);
    step(1);
    check("ch3_irq", irq, 1);
    pop_id("ch3_id");
    step(2);
    int_taken = 1'b1; step(1); int_taken = 1'b0;
    check("ch3_svc", in_service, 1);
    check("ch3_set_wins", pending, 6'h08);
    exp_q.push_back(3);
    rti = 1'b1; step(1); rti = 1'b0;
    check("ch3_idle_gap", irq, 0);
    step(1);
    check("ch3_rereq", irq, 1);
    pop_id("ch3_id2");
    int_taken = 1'b1; step(1); int_taken = 1'b0;
    check("ch3_svc2", in_service, 1);

    // Asynchronous reset mid-service
    #2 reset = 1'b0;
    #1;
    check("arst_svc", in_service, 0);
    check("arst_irq", irq, 0);
    check("arst_id", irq_id, 0);
    check("arst_pend", pending, 0);
    step(1);
    reset = 1'b1;
    step(6);
    check("post_rst_pend", pending, 0);
    check("post_rst_irq", irq, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_timer_ctrl.md
Name: irq_timer_ctrl

Overview:
- Parametrised multi-source interrupt controller; successor to the single counter-interrupt path in the pipeline controller.
- Provides NCNT programmable down-counter interrupt channels and NEXT edge-triggered external lines (e.g. lightgun, audio, vblank).
- Uses fixed priority with a request/take/return handshake toward fetch.
- Programmed by the E-stage counter-interrupt instruction; the handler's "what interrupt" instruction reads back irq_id.

Parameters:
- NCNT, 4, number of counter channels.
- NEXT, 2, number of external request lines.
- CNTW, 16, counter/period width in bits.
- IDW, 3, width of irq_id; must satisfy 2^IDW >= NCNT+NEXT.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low; 0 resets all state.
- stall, input, 1, pipeline stall; blocks all instruction-driven actions (cfg, take, rti).
- cnt_int_we, input, 1, counter-interrupt instruction valid in E stage.
- cnt_int_sel, input, 1, with cnt_int_we: load period and enable the channel.
- cnt_int_disable, input, 1, with cnt_int_we: disable the channel and clear its pending bit; wins over sel.
- cnt_ch, input, IDW, channel index for the cfg op; values >= NCNT are ignored.
- cnt_period, input, CNTW, period in cycles.
- ext_irq, input, NEXT, external request lines; sampled every cycle, rising edge is the event.
- int_en, input, 1, global interrupt enable.
- int_taken, input, 1, pipeline accepts the interrupt this cycle.
- rti, input, 1, return-from-interrupt retiring.
- irq, output, 1, interrupt request to fetch.
- irq_id, output, IDW, id of the requested/in-service source.
- in_service, output, 1, handler active.
- pending, output, NCNT+NEXT, pending bits; bit i is source i.

Behaviour:
- Reset (reset=0, async): counters=0, periods=0, channel enables=0, pending=0, ext edge history=0, state=IDLE, irq=0, irq_id=0, in_service=0.
- Cfg ops take effect only when cnt_int_we & ~stall.
  - sel: period[ch]<=cnt_period, count[ch]<=cnt_period, en[ch]<=1; the pending bit is untouched.
  - disable: en[ch]<=0, pending[ch]<=0.
  - A period of 0 loads en=0.
- Counter, when en: free-running and independent of stall.
  - If count>1: count-1.
  - If count==1: count<=period and pending[ch] set at that same edge.
  - With period P, pending sets every P cycles; first set is P cycles after the cfg edge.
- External line j: pending[NCNT+j] is set at the edge where ext_irq[j]=1 and the previous sample was 0. A level held high produces one event.
- Priority: lowest index wins; counters outrank externals.
- State machine:
  - IDLE: if int_en & |pending, then REQ and latch irq_id = highest-priority pending index.
  - REQ: irq=1 and irq_id is held stable even if a higher-priority source arrives.
    - If int_taken & ~stall: clear pending[irq_id], go to SERVICE.
    - If pending[irq_id] is cleared by disable, or int_en drops: back to IDLE with irq=0 next cycle.
  - SERVICE: in_service=1, irq=0, no nesting; new events still accumulate in pending.
    - rti & ~stall: go to IDLE.
    - int_taken in SERVICE is ignored.
- Latency: the event edge sets pending, the next edge enters REQ, so irq is high 2 cycles after the counter shows 1.
- Simultaneous events:
  - Set and take-clear of the same bit in the same cycle: set wins, and the source re-requests after rti.
  - Disable and expiry of the same channel in the same cycle: disable wins, pending=0.
  - rti and a pending source in the same cycle: IDLE for one cycle, then REQ; there are no back-to-back REQ without IDLE.
- Reset asserted mid-REQ/SERVICE returns to IDLE immediately; irq and in_service drop asynchronously.

Test Plan:
- Reset with ext_irq=1 held, then release: no event, pending=0, irq=0 until a 0→1 edge occurs.
- Cfg ch1 with period=5, int_en=1: pending[1] sets every 5 cycles, irq rises 2 cycles after count==1, irq_id=1; with int_taken pulsed, pending[1] clears, in_service=1 until rti, then the cycle repeats.
- Ch0 and ext line 0 (id 4) fire in the same cycle: irq_id=0 first; after rti there is 1 IDLE cycle, then REQ with irq_id=4.
- In REQ for ch2, issue disable ch2: pending[2]=0, irq=0 next cycle, state=IDLE.
- Hold stall=1 while int_taken=1 in REQ: state stays REQ and pending unchanged; take completes on the first unstalled cycle.
- Ch3 expiry on the same edge as int_taken for id 3: pending[3] remains 1; after rti, REQ id 3 again. Also pulse reset mid-SERVICE: outputs return to reset values at once.
